// File: rtl/aes128_decrypt_iter_if.sv
// Ciphertext/key request channel and plaintext response channel for aes128_decrypt_iter.
// Signals: in_valid/in_ready/ciphertext/key (request) and out_valid/out_ready/plaintext (response).
// master = block source plus plaintext sink; slave = the decryptor.
interface aes128_decrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext
    );
endinterface

// File: rtl/aes128_decrypt_iter.sv
// Purpose: iterative AES-128 inverse cipher, one round per clock, round keys re-derived in reverse.
// Latency: out_valid 21 edges after accept (11 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined).
// Backpressure: in_ready only in IDLE; plaintext held in DONE until out_ready, no block overlap.
// Ports: clk, rst_n (async active-low), bus (slave): in_valid/in_ready/ciphertext/key in,
// out_valid/out_ready/plaintext out. Byte 0 of every 128-bit word is bits [127:120].
module aes128_decrypt_iter (
    input  logic                 clk,
    input  logic                 rst_n,
    aes128_decrypt_iter_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] KEYGEN = 3'd1;
    localparam logic [2:0] INIT   = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] FINAL  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]   state;
    logic [3:0]   rc;
    logic [127:0] st;
    logic [127:0] rk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            m9[i] = xtime(xtime(xtime(a[i]))) ^ a[i];
            mb[i] = m9[i] ^ xtime(a[i]);
            md[i] = m9[i] ^ xtime(xtime(a[i]));
            me[i] = md[i] ^ xtime(a[i]) ^ a[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Key path: the four forward S-boxes see RotWord(w3) while expanding forward and
    // RotWord(w3^w2) (the recovered previous w3) while stepping backwards.
    logic [31:0]  w0, w1, w2, w3, sw_in, sw_out, kt;
    logic [127:0] rk_fwd, rk_inv;

    always_comb begin
        w0     = rk[127:96];
        w1     = rk[95:64];
        w2     = rk[63:32];
        w3     = rk[31:0];
        sw_in  = (state == KEYGEN) ? w3 : (w3 ^ w2);
        sw_in  = {sw_in[23:0], sw_in[31:24]};
        sw_out = '0;
        for (int i = 0; i < 4; i++) sw_out[31-8*i -: 8] = sbox(sw_in[31-8*i -: 8]);
        kt     = sw_out ^ {rcon(rc), 24'h000000};
        rk_fwd[127:96] = w0 ^ kt;
        rk_fwd[95:64]  = w1 ^ rk_fwd[127:96];
        rk_fwd[63:32]  = w2 ^ rk_fwd[95:64];
        rk_fwd[31:0]   = w3 ^ rk_fwd[63:32];
        rk_inv = {w0 ^ kt, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    // State path: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
    logic [127:0] isr, isb, ark, imc;

    always_comb begin
        isr = '0;
        isb = '0;
        imc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
        for (int i = 0; i < 16; i++) isb[127-8*i -: 8] = inv_sbox(isr[127-8*i -: 8]);
        ark = isb ^ rk;
        for (int c = 0; c < 4; c++) imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic [127:0] cache_rk10;
    logic         cache_vld;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rc    <= 4'd0;
            st    <= '0;
            rk    <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key  <= '0;
            cache_rk10 <= '0;
            cache_vld  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    st <= bus.ciphertext;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_vld && (bus.key == cache_key)) begin
                        rk    <= cache_rk10;
                        rc    <= 4'd10;
                        state <= INIT;
                    end else begin
                        // Key captured now; the entry becomes valid once rk10 is known.
                        rk        <= bus.key;
                        rc        <= 4'd1;
                        state     <= KEYGEN;
                        cache_key <= bus.key;
                        cache_vld <= 1'b0;
                    end
`else
                    rk    <= bus.key;
                    rc    <= 4'd1;
                    state <= KEYGEN;
`endif
                end
                KEYGEN: begin
                    rk <= rk_fwd;
                    if (rc == 4'd10) begin
                        // rc stays 10 so INIT steps back from rk10 with Rcon[10].
                        state <= INIT;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_rk10 <= rk_fwd;
                        cache_vld  <= 1'b1;
`endif
                    end else begin
                        rc <= rc + 4'd1;
                    end
                end
                INIT: begin
                    st    <= st ^ rk;
                    rk    <= rk_inv;
                    rc    <= 4'd9;
                    state <= ROUND;
                end
                ROUND: begin
                    st <= imc;
                    rk <= rk_inv;
                    rc <= rc - 4'd1;
                    if (rc == 4'd1) state <= FINAL;
                end
                FINAL: begin
                    st    <= ark;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.plaintext = st;
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS-197 vectors, cache/latency sequence, backpressure,
// mid-round reset and 1000 random blocks encrypted by a byte-array AES-128 reference model.
module tb_aes128_decrypt_iter;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic hold;
    logic full_rdy;

    aes128_decrypt_iter_if bus();

    aes128_decrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]   sbox [0:255];
    logic         m_vld;
    logic [127:0] m_key;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward AES-128 on byte arrays, used to make ciphertext for random plaintexts.
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   w [0:175];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   tmp [0:3];
        logic [7:0]   x, rcv, a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        rcv = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x      = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rcv;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[x];
                rcv    = xt(rcv);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Offer one block; pushes its expectation just before the accepting edge.
    // Called right after a falling edge; returns right after the falling edge following acceptance.
    task automatic issue(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt);
        exp_t e;
        int   n;
        n = 0;
        bus.ciphertext = ct;
        bus.key        = k;
        bus.in_valid   = 1'b1;
        while (!bus.in_ready) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++; errors++;
                $display("FAIL accept_timeout in_ready stayed %b, required 1", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.pt  = pt;
        e.acc = cyc + 1;
`ifdef AES_DEC_KEY_CACHE_EN
        if (m_vld && k == m_key) e.lat = 11;
        else begin
            e.lat = 21;
            m_key = k;
            m_vld = 1'b1;
        end
`else
        e.lat = 21;
`endif
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
        bus.key        = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || bus.out_valid) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++; errors++;
                $display("FAIL drain_timeout pending %0d required 0", exp_q.size());
                exp_q.delete();
                return;
            end
        end
    endtask

    // Sink: random out_ready unless held low or forced high.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = hold ? 1'b0 : (full_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
        end
    end

    // Monitor: each new out_valid pops one expectation and checks data and latency.
    initial begin
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) seen = 1'b0;
            else if (bus.out_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid plaintext %h with no block pending", bus.plaintext);
                end else begin
                    e = exp_q.pop_front();
                    chk("plaintext", bus.plaintext, e.pt);
                    chk("latency", 128'(cyc - e.acc), 128'(e.lat));
                end
            end else if (!bus.out_valid) seen = 1'b0;
        end
    end

    initial begin
        logic [7:0]   p, q, x;
        logic [127:0] k, pt, last_k;
        int           n;

        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;

        m_vld          = 1'b0;
        m_key          = '0;
        hold           = 1'b0;
        full_rdy       = 1'b0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_plaintext", bus.plaintext, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known vectors back to back, then the C.1 key twice more (second repeat hits the cache).
        issue(C1_CT, C1_KEY, C1_PT);
        issue(B_CT, B_KEY, B_PT);
        issue(C1_CT, C1_KEY, C1_PT);
        issue(C1_CT, C1_KEY, C1_PT);
        drain();

        // Backpressure: plaintext held with out_ready low, in_valid pulses ignored.
        hold = 1'b1;
        @(negedge clk);
        issue(C1_CT, C1_KEY, C1_PT);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 128'(bus.out_valid), 128'd1);
        for (int i = 0; i < 50; i++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
            bus.key        = B_KEY;
            @(negedge clk);
            chk("bp_plaintext", bus.plaintext, C1_PT);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
        end
        bus.in_valid = 1'b0;
        full_rdy     = 1'b1;
        hold         = 1'b0;
        n = 0;
        while (bus.out_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("bp_release_out_valid", 128'(bus.out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'd1);
        full_rdy = 1'b0;
        drain();

        // Reset while in ROUND with rc=5 (15 edges after accepting a fresh key).
        k = {$urandom, $urandom, $urandom, $urandom} ^ 128'h5a;
        pt = {$urandom, $urandom, $urandom, $urandom};
        issue(aes_enc(k, pt), k, pt);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst_plaintext", bus.plaintext, 128'd0);
        exp_q.delete();
        m_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("midrst_no_output", 128'(bus.out_valid), 128'd0);
        end
        issue(C1_CT, C1_KEY, C1_PT);
        drain();

        // Random blocks; about a quarter reuse the previous key.
        last_k = C1_KEY;
        for (int i = 0; i < 1000; i++) begin
            k  = ($urandom_range(0, 3) == 0) ? last_k : {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            last_k = k;
            issue(aes_enc(k, pt), k, pt);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
